// File: rtl/descrambler_byte_pkg.sv
// descrambler_byte_pkg
// Shared PHY constants for the USB3 Gen1 byte scrambler/descrambler pair:
// the COM/SKP K-code byte values, the LFSR seed, and the lock FSM state enum.
// The transmit scrambler imports the same package so both ends agree on the
// re-seed and freeze rules.
//
// Optional build macro used by importers: DESCRAMBLER_BYPASS_EN.

package descrambler_byte_pkg;

    // K28.5 re-seeds the LFSR, K28.1 leaves the LFSR frozen
    localparam logic [7:0]  COM_CODE  = 8'hBC;
    localparam logic [7:0]  SKP_CODE  = 8'h3C;
    localparam logic [15:0] LFSR_SEED = 16'hFFFF;

    // Alignment state of the receive LFSR
    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    // True when a qualified K symbol carries the given control code.
    // A data byte (k = 0) with the same value never matches.
    function automatic logic is_ctrl_code(
        input logic [7:0] data,
        input logic       k,
        input logic       valid,
        input logic [7:0] code
    );
        return valid && k && (data == code);
    endfunction

endpackage

// File: rtl/descrambler_byte_if.sv
// descrambler_byte_if
// Symbol bus between the 8b/10b decoder / LTSSM side and the descrambler.
//
// Signals:
//   data_in        decoded symbol byte
//   data_k         1 = control (K) symbol
//   data_valid     symbol qualifier
//   lock_clr       synchronous drop-lock request from the LTSSM
//   data_out       descrambled byte (1-cycle latency)
//   data_k_out     registered copy of data_k
//   data_valid_out registered copy of data_valid
//   locked         1 once a COM has been seen since reset/lock_clr
//
// Modports:
//   master  upstream driver of symbols (decoder/LTSSM, or a testbench)
//   slave   the descrambler itself

interface descrambler_byte_if;

    logic [7:0] data_in;
    logic       data_k;
    logic       data_valid;
    logic       lock_clr;
    logic [7:0] data_out;
    logic       data_k_out;
    logic       data_valid_out;
    logic       locked;

    modport master (
        output data_in,
        output data_k,
        output data_valid,
        output lock_clr,
        input  data_out,
        input  data_k_out,
        input  data_valid_out,
        input  locked
    );

    modport slave (
        input  data_in,
        input  data_k,
        input  data_valid,
        input  lock_clr,
        output data_out,
        output data_k_out,
        output data_valid_out,
        output locked
    );

endinterface

// File: rtl/descrambler_byte_lfsr16_byte_step.sv
// lfsr16_byte_step
// Purely combinational 8-step advance of the x^16+x^5+x^4+x^3+1 Fibonacci
// LFSR. Bit 0 of the keystream is the first bit shifted out.
// Shared by the transmit scrambler and the receive descrambler.
//
// Ports:
//   lfsr_cur   in  16  current LFSR state
//   lfsr_next  out 16  LFSR state after 8 steps
//   keystream  out 8   the 8 output bits, bit 0 first

module lfsr16_byte_step (
    input  logic [15:0] lfsr_cur,
    output logic [15:0] lfsr_next,
    output logic [7:0]  keystream
);

    logic [15:0] lfsr_walk;

    // Unrolled 8-step walk: each step emits lfsr[15] and shifts the
    // feedback tap sum into bit 0.
    always_comb begin
        lfsr_walk = lfsr_cur;
        keystream = 8'h00;
        for (int i = 0; i < 8; i++) begin
            keystream[i] = lfsr_walk[15];
            lfsr_walk    = {lfsr_walk[14:0],
                            lfsr_walk[15] ^ lfsr_walk[4] ^ lfsr_walk[3] ^ lfsr_walk[2]};
        end
        lfsr_next = lfsr_walk;
    end

endmodule

// File: rtl/descrambler_byte.sv
// descrambler_byte
// Receive-side byte descrambler for the USB3 Gen1 PHY path. Removes the
// scrambling applied by the transmit scrambler, re-seeds on COM, freezes on
// SKP, and reports alignment through a two-state lock FSM.
//
// Ports:
//   clk           in  symbol clock
//   rst_n         in  asynchronous active-low reset
//   scramble_dis  in  (only with DESCRAMBLER_BYPASS_EN) pass data unmodified
//   bus           descrambler_byte_if.slave symbol in/out bus
//
// Build macro: DESCRAMBLER_BYPASS_EN adds the scramble_dis loopback input.
// Without it, data symbols are always descrambled.

module descrambler_byte
    import descrambler_byte_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
`ifdef DESCRAMBLER_BYPASS_EN
    input  logic scramble_dis,
`endif
    descrambler_byte_if.slave bus
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic [15:0] lfsr_stepped;
    logic [7:0]  keystream;
    logic [7:0]  xor_mask;
    logic [7:0]  descrambled;
    logic        is_com;
    logic        is_skp;

    lock_state_t state_q;
    lock_state_t state_d;

    logic [7:0]  data_out_q;
    logic        data_k_out_q;
    logic        data_valid_out_q;

    lfsr16_byte_step u_step (
        .lfsr_cur  (lfsr_q),
        .lfsr_next (lfsr_stepped),
        .keystream (keystream)
    );

    assign is_com = is_ctrl_code(bus.data_in, bus.data_k, bus.data_valid, COM_CODE);
    assign is_skp = is_ctrl_code(bus.data_in, bus.data_k, bus.data_valid, SKP_CODE);

    // In bypass mode only the XOR is suppressed; the LFSR keeps tracking
    // the stream so clearing scramble_dis resumes without realignment.
`ifdef DESCRAMBLER_BYPASS_EN
    assign xor_mask = scramble_dis ? 8'h00 : keystream;
`else
    assign xor_mask = keystream;
`endif

    assign descrambled = bus.data_k ? bus.data_in : (bus.data_in ^ xor_mask);

    // LFSR next-state: lock_clr wins over everything, including an idle
    // cycle; COM re-seeds, SKP and idle cycles freeze, any other symbol
    // (data or other K code) advances one byte.
    always_comb begin
        lfsr_d = lfsr_q;
        if (bus.lock_clr) begin
            lfsr_d = LFSR_SEED;
        end else if (!bus.data_valid) begin
            lfsr_d = lfsr_q;
        end else if (is_com) begin
            lfsr_d = LFSR_SEED;
        end else if (is_skp) begin
            lfsr_d = lfsr_q;
        end else begin
            lfsr_d = lfsr_stepped;
        end
    end

    // LFSR register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    // Lock FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNLOCKED;
        end else begin
            state_q <= state_d;
        end
    end

    // Lock FSM next-state: lock_clr beats a simultaneous COM
    always_comb begin
        state_d = state_q;
        if (bus.lock_clr) begin
            state_d = UNLOCKED;
        end else if (is_com) begin
            state_d = LOCKED;
        end
    end

    // Lock FSM outputs
    always_comb begin
        bus.locked = (state_q == LOCKED);
    end

    // Output stage: data_out only updates on qualified symbols; the k and
    // valid flags are straight registered copies of the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q       <= 8'h00;
            data_k_out_q     <= 1'b0;
            data_valid_out_q <= 1'b0;
        end else begin
            if (bus.data_valid) begin
                data_out_q <= descrambled;
            end
            data_k_out_q     <= bus.data_k;
            data_valid_out_q <= bus.data_valid;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.data_k_out     = data_k_out_q;
    assign bus.data_valid_out = data_valid_out_q;

endmodule

// File: tb/tb_descrambler_byte.sv
// tb_descrambler_byte
// Directed testbench for descrambler_byte. Expected bytes are the keystream
// from the 16'hFFFF seed: FF, FF, 28, C1, 8A for bytes 0..4 after a seed
// load. Each row of a table is one symbol; the expected word is
// {data_out, data_k_out, data_valid_out, locked}. data_k_out is not
// compared in cycles whose expected data_valid_out is 0.
//
// Build macro: DESCRAMBLER_BYPASS_EN enables the scramble_dis scenario.

module tb_descrambler_byte;

    import descrambler_byte_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
`ifdef DESCRAMBLER_BYPASS_EN
    logic scramble_dis;
`endif

    int compared   = 0;
    int mismatched = 0;

    descrambler_byte_if bus ();

    descrambler_byte dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef DESCRAMBLER_BYPASS_EN
        .scramble_dis (scramble_dis),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    // Drive one symbol, let the DUT sample it, and settle past the edge
    task automatic applyStimulus(input logic [7:0] d, input logic k,
                                 input logic v, input logic clr);
        bus.data_in    = d;
        bus.data_k     = k;
        bus.data_valid = v;
        bus.lock_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [10:0] got;
        rst_n = 1'b0;
        bus.data_in = 8'hBC; bus.data_k = 1'b1; bus.data_valid = 1'b1; bus.lock_clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
        compared++;
        if (got !== 11'h000) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs got=%h expected=000", got);
        end
        compared++;
        if (dut.lfsr_q !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL reset_lfsr got=%h expected=ffff", dut.lfsr_q);
        end
        compared++;
        if (dut.state_q !== UNLOCKED) begin
            mismatched++;
            $display("[TB] FAIL reset_state got=%b expected=0", dut.state_q);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_com_data();
        logic [7:0]  din [6];
        logic        kin [6];
        logic [10:0] exp_v [6];
        logic [10:0] got;
        din   = '{8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'hFF, 3'b011}, {8'hFF, 3'b011},
                  {8'h28, 3'b011}, {8'hC1, 3'b011}, {8'h8A, 3'b011}};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL com_data[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
            if (i == 1) begin
                compared++;
                if (dut.lfsr_q !== 16'hFF14) begin
                    mismatched++;
                    $display("[TB] FAIL com_data_lfsr got=%h expected=ff14", dut.lfsr_q);
                end
            end
        end
    endtask

    task automatic test_skp_freeze();
        logic [7:0]  din [5];
        logic        kin [5];
        logic [10:0] exp_v [5];
        logic [10:0] got;
        din   = '{8'hBC, 8'h00, 8'h3C, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'hFF, 3'b011}, {8'h3C, 3'b111},
                  {8'hFF, 3'b011}, {8'h28, 3'b011}};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL skp_freeze[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_k_advance();
        logic [7:0]  din [5];
        logic        kin [5];
        logic [10:0] exp_v [5];
        logic [10:0] got;
        din   = '{8'hBC, 8'h00, 8'hFB, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'hFF, 3'b011}, {8'hFB, 3'b111},
                  {8'h28, 3'b011}, {8'hC1, 3'b011}};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL k_advance[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_data_lookalike();
        logic [7:0]  din [4];
        logic        kin [4];
        logic [10:0] exp_v [4];
        logic [10:0] got;
        din   = '{8'hBC, 8'hBC, 8'h3C, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'h43, 3'b011}, {8'hC3, 3'b011}, {8'h28, 3'b011}};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL data_lookalike[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

    // The idle cycles present a COM byte with valid low; it must be ignored
    task automatic test_valid_gap();
        logic [7:0]  din [10];
        logic        kin [10];
        logic        vin [10];
        logic [10:0] exp_v [10];
        logic [10:0] got;
        din   = '{8'hBC, 8'h00, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'hBC, 8'h00, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vin   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_v = '{{8'hBC, 3'b111}, {8'hFF, 3'b011},
                  {8'hFF, 3'b001}, {8'hFF, 3'b001}, {8'hFF, 3'b001},
                  {8'hFF, 3'b001}, {8'hFF, 3'b001},
                  {8'hFF, 3'b011}, {8'h28, 3'b011}, {8'hC1, 3'b011}};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(din[i], kin[i], vin[i], 1'b0);
            got = {bus.data_out, bus.data_valid_out ? bus.data_k_out : 1'b0,
                   bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL valid_gap[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_lock_clr();
        logic [7:0]  din [9];
        logic        kin [9];
        logic        vin [9];
        logic        cin [9];
        logic [10:0] exp_v [9];
        logic [10:0] got;
        din   = '{8'hBC, 8'h00, 8'h00, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vin   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        cin   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b110}, {8'hFF, 3'b010}, {8'hFF, 3'b010},
                  {8'hBC, 3'b111}, {8'hFF, 3'b011}, {8'hFF, 3'b000},
                  {8'hFF, 3'b010}, {8'hFF, 3'b010}, {8'h28, 3'b010}};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(din[i], kin[i], vin[i], cin[i]);
            got = {bus.data_out, bus.data_valid_out ? bus.data_k_out : 1'b0,
                   bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL lock_clr[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
            if (cin[i]) begin
                compared++;
                if (dut.lfsr_q !== 16'hFFFF) begin
                    mismatched++;
                    $display("[TB] FAIL lock_clr_lfsr[%0d] got=%h expected=ffff", i, dut.lfsr_q);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  din [6];
        logic        kin [6];
        logic [10:0] exp_v [6];
        logic [10:0] got;
        din   = '{8'hBC, 8'hA5, 8'h3C, 8'h12, 8'h34, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'h5A, 3'b011}, {8'hC3, 3'b011},
                  {8'h3A, 3'b011}, {8'hF5, 3'b011}, {8'h8A, 3'b011}};
        for (int i = 0; i < 6; i++) begin
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL back_to_back[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [10:0] exp_v [3];
        logic [10:0] got;
        applyStimulus(8'hBC, 1'b1, 1'b1, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
        compared++;
        if (got !== 11'h000) begin
            mismatched++;
            $display("[TB] FAIL midreset_outputs got=%h expected=000", got);
        end
        compared++;
        if (dut.lfsr_q !== 16'hFFFF) begin
            mismatched++;
            $display("[TB] FAIL midreset_lfsr got=%h expected=ffff", dut.lfsr_q);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_v = '{{8'hFF, 3'b010}, {8'hFF, 3'b010}, {8'h28, 3'b010}};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'h00, 1'b0, 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL midreset[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
    endtask

`ifdef DESCRAMBLER_BYPASS_EN
    task automatic test_bypass();
        logic [7:0]  din [5];
        logic        kin [5];
        logic        sdis [5];
        logic [10:0] exp_v [5];
        logic [10:0] got;
        din   = '{8'hBC, 8'h5A, 8'hA5, 8'h00, 8'h00};
        kin   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        sdis  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        exp_v = '{{8'hBC, 3'b111}, {8'h5A, 3'b011}, {8'hA5, 3'b011},
                  {8'h28, 3'b011}, {8'hC1, 3'b011}};
        for (int i = 0; i < 5; i++) begin
            scramble_dis = sdis[i];
            applyStimulus(din[i], kin[i], 1'b1, 1'b0);
            got = {bus.data_out, bus.data_k_out, bus.data_valid_out, bus.locked};
            compared++;
            if (got !== exp_v[i]) begin
                mismatched++;
                $display("[TB] FAIL bypass[%0d] got=%h expected=%h", i, got, exp_v[i]);
            end
        end
        scramble_dis = 1'b0;
    endtask
`endif

    initial begin
        rst_n = 1'b0;
`ifdef DESCRAMBLER_BYPASS_EN
        scramble_dis = 1'b0;
`endif
        $display("[TB] descrambler_byte directed tests start");
        test_reset();
        test_com_data();
        test_skp_freeze();
        test_k_advance();
        test_data_lookalike();
        test_valid_gap();
        test_lock_clr();
        test_back_to_back();
        test_reset_midstream();
`ifdef DESCRAMBLER_BYPASS_EN
        test_bypass();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
